// File: rtl/lfsr_roller_pkg.sv
// Shared constants and helpers for the multi-channel LFSR dice roller.
package lfsr_roller_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_ROLL = 1'b1;

  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [31:0] SALT       = 32'h9E37_79B9;
  localparam logic [31:0] RESET_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] sh;
    sh = {1'b0, s[31:1]};
    return s[0] ? (sh ^ POLY) : sh;
  endfunction

  // Per-channel seed derivation; an all-zero LFSR would lock up, so zero maps to 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] seed, input int unsigned c);
    logic [31:0] v;
    v = seed ^ (32'(c) * SALT);
    return (v == 32'h0000_0000) ? 32'h0000_0001 : v;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// One free-running 32-bit Galois LFSR with a synchronous seed load.
module lfsr_galois
  import lfsr_roller_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_SEED,
  parameter int          OUT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [31:0]       i_seed,
  output logic [OUT_W-1:0]  o_state
);

  logic [31:0] state_d;
  logic [31:0] state_q;

  always_comb begin
    if (i_load) begin
      state_d = i_seed;
    end else begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q[OUT_W-1:0];

endmodule

// File: rtl/lfsr_roller.sv
// Multi-channel dice roller: free-running LFSRs sampled on a decelerating
// or fixed-rate schedule after a start pulse.
module lfsr_roller
  import lfsr_roller_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4,
  parameter int BASE_DIV = 2500000,
  parameter int STEPS    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_mode,
  input  logic                      i_load,
  input  logic [31:0]               i_seed,
  output logic [CHANNELS*WIDTH-1:0] o_value,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CW = $clog2(BASE_DIV * STEPS + 1);
  localparam int SW = $clog2(STEPS + 1);
  localparam int VW = CHANNELS * WIDTH;

  localparam logic [CW-1:0] BASE_C    = CW'(BASE_DIV);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  logic [WIDTH-1:0] lfsr_s [CHANNELS];
  logic [VW-1:0]    capture_s;
  logic [CW-1:0]    interval_m1_s;
  logic             tick_s;
  logic             load_s;

  state_t        state_d, state_q;
  logic          mode_d,  mode_q;
  logic [CW-1:0] cnt_d,   cnt_q;
  logic [SW-1:0] step_d,  step_q;
  logic [VW-1:0] value_d, value_q;
  logic          busy_d,  busy_q;
  logic          done_d,  done_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [31:0] seed_s;
    assign seed_s = chan_seed(i_seed, c);

    lfsr_galois #(
      .RESET_VAL (chan_seed(RESET_SEED, c)),
      .OUT_W     (WIDTH)
    ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (load_s),
      .i_seed  (seed_s),
      .o_state (lfsr_s[c])
    );
  end

  always_comb begin
    capture_s = {VW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      capture_s[c*WIDTH +: WIDTH] = lfsr_s[c];
    end
  end

  // Decelerating mode stretches each interval by one BASE_DIV per completed step.
  assign interval_m1_s = mode_q ? (BASE_C - CW'(1'b1))
                                : (BASE_C * (CW'(step_q) + CW'(1'b1)) - CW'(1'b1));
  assign tick_s = (cnt_q == interval_m1_s);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    value_d = value_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_s = i_load;
        if (i_start) begin
          state_d = ST_ROLL;
          mode_d  = i_mode;
          cnt_d   = {CW{1'b0}};
          step_d  = {SW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_ROLL: begin
        // A stop landing on an interval tick still yields a single capture.
        if (i_stop || tick_s) begin
          value_d = capture_s;
          cnt_d   = {CW{1'b0}};
          if (i_stop || (!mode_q && (step_q == LAST_STEP))) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!mode_q) begin
            step_d  = step_q + SW'(1'b1);
          end else begin
            step_d  = step_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      step_q  <= {SW{1'b0}};
      value_q <= {VW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_value = value_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_lfsr_roller.sv
// Scoreboard bench for lfsr_roller: a schedule-based reference model predicts
// outputs after every edge, a monitor compares them on the falling edge.
module tb_lfsr_roller;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int BD = 4;
  localparam int ST = 3;
  localparam logic [31:0] T_POLY = 32'h8020_0003;
  localparam logic [31:0] T_SALT = 32'h9E37_79B9;

  logic        clk;
  logic        i_rst, i_start, i_stop, i_mode, i_load;
  logic [31:0] i_seed;
  logic [7:0]  o_value;
  logic        o_busy, o_done;

  lfsr_roller #(.CHANNELS(CH), .WIDTH(W), .BASE_DIV(BD), .STEPS(ST)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_stop  (i_stop),
    .i_mode  (i_mode),
    .i_load  (i_load),
    .i_seed  (i_seed),
    .o_value (o_value),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] v;
    logic       b;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [31:0] adv(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ T_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] seedv(input logic [31:0] s, input int c);
    logic [31:0] v;
    v = s ^ (32'(c) * T_SALT);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  // Capture k (1-based) lands this many edges after the start edge.
  function automatic int cap_off(input logic md, input int k);
    return md ? BD * k : (BD * k * (k + 1)) / 2;
  endfunction

  // Reference model: triangular / fixed capture schedule over plain LFSR arrays.
  logic [31:0] m_lfsr [CH];
  logic [31:0] m_pre  [CH];
  logic [7:0]  m_value;
  logic        m_busy, m_done, m_mode;
  int          m_e0, m_k;

  initial begin : model
    exp_t e;
    m_busy = 1'b0;
    forever begin
      @(posedge clk);
      for (int c = 0; c < CH; c++) m_pre[c] = m_lfsr[c];
      m_done = 1'b0;
      if (!i_rst) begin
        m_value = 8'h00;
        m_busy  = 1'b0;
        for (int c = 0; c < CH; c++) m_lfsr[c] = seedv(32'h1, c);
      end else if (!m_busy) begin
        for (int c = 0; c < CH; c++) m_lfsr[c] = i_load ? seedv(i_seed, c) : adv(m_pre[c]);
        if (i_start) begin
          m_busy = 1'b1;
          m_mode = i_mode;
          m_e0   = cyc;
          m_k    = 1;
        end
      end else begin
        for (int c = 0; c < CH; c++) m_lfsr[c] = adv(m_pre[c]);
        if (i_stop || (cyc == m_e0 + cap_off(m_mode, m_k))) begin
          for (int c = 0; c < CH; c++) m_value[c*W +: W] = m_pre[c][W-1:0];
          if (i_stop || (!m_mode && (m_k == ST))) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
          m_k++;
        end
      end
      e.v = m_value;
      e.b = m_busy;
      e.d = m_done;
      exp_q.push_back(e);
      cyc++;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({o_value, o_busy, o_done} !== {e.v, e.b, e.d}) begin
          failures++;
          $display("FAIL scoreboard edge=%0d got value=%h busy=%b done=%b, expected value=%h busy=%b done=%b",
                   cyc - 1, o_value, o_busy, o_done, e.v, e.b, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc1(input logic st, input logic sp, input logic md, input logic ld,
                      input logic [31:0] sd);
    i_start = st;
    i_stop  = sp;
    i_mode  = md;
    i_load  = ld;
    i_seed  = sd;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_mode  = 1'b0;
    i_load  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b1;
  endtask

  task automatic wait_idle(input int e0, input int exp_len, input string name);
    int n;
    n = 0;
    while (o_busy && n < 80) begin
      cyc1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    if (o_busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=busy expected=idle within 80 cycles", name);
      do_reset();
    end else begin
      check({name, "_len"}, 32'(cyc - 1 - e0), 32'(exp_len));
      check({name, "_done"}, {31'h0, o_done}, 32'h1);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int e0;
    int n;
    int stop_at;
    logic md;
    i_rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0; i_load = 1'b0; i_seed = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b1;
    check("reset_value", {24'h0, o_value}, 32'h0);
    check("reset_busy_done", {30'h0, o_busy, o_done}, 32'h0);

    // Seed 1 with simultaneous start, decelerating mode.
    cyc1(1'b1, 1'b0, 1'b0, 1'b1, 32'h1);
    e0 = cyc - 1;
    check("start_busy", {31'h0, o_busy}, 32'h1);
    idle(4);
    check("seed1_first_capture", {24'h0, o_value}, 32'h71);
    wait_idle(e0, 24, "mode0");
    idle(2);

    // Zero seed, plus start/load pulses that must be ignored while rolling.
    cyc1(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    e0 = cyc - 1;
    idle(4);
    check("seed0_ch0_not_stuck", {28'h0, o_value[3:0]}, 32'h1);
    cyc1(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cyc1(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    wait_idle(e0, 24, "mode0_ignored");

    // Continuous mode stopped at E0+10.
    idle(1);
    cyc1(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    e0 = cyc - 1;
    idle(9);
    cyc1(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("stop_edge", 32'(cyc - 1 - e0), 32'd10);
    check("stop_done_busy", {30'h0, o_done, o_busy}, 32'h2);
    idle(8);

    // Reset in the middle of a roll, then an immediate fresh roll.
    cyc1(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    e0 = cyc - 1;
    idle(5);
    do_reset();
    check("midroll_reset_outputs", {22'h0, o_value, o_busy, o_done}, 32'h0);
    cyc1(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    e0 = cyc - 1;
    wait_idle(e0, 24, "after_reset");

    // Randomized rolls with stray inputs and random stop points.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3))
        cyc1(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom);
      md      = 1'($urandom_range(0, 1));
      stop_at = md ? $urandom_range(1, 20) : $urandom_range(1, 40);
      cyc1(1'b1, 1'b0, md, 1'($urandom_range(0, 1)), $urandom);
      n = 0;
      while (o_busy && n < 100) begin
        n++;
        cyc1($urandom_range(0, 3) == 0, n == stop_at, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, $urandom);
      end
      if (o_busy) begin
        checks++;
        failures++;
        $display("FAIL random_roll_timeout got=busy expected=idle iteration=%0d", it);
        do_reset();
      end
    end

    idle(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
